// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one HyperBus controller between NPORTS request/hold-until-done ports.
// Latency: grant one cycle after a pending request is seen idle; done pulses one cycle after busy falls.
// Backpressure: waiting ports hold their requests until granted; no preemption; timeout/ctl error is terminal.
module hyperbus_arbiter #(
    parameter int NPORTS  = 2,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NPORTS*32-1:0]      req_adr_i,
    input  logic [NPORTS*2*WIDTH-1:0] req_dat_i,
    input  logic [NPORTS-1:0]         req_reg_space_i,
    input  logic [NPORTS-1:0]         req_rrq_i,
    input  logic [NPORTS-1:0]         req_wrq_i,
    output logic [2*WIDTH-1:0]        req_dat_o,
    output logic [NPORTS-1:0]         req_valid_o,
    output logic [NPORTS-1:0]         req_ready_o,
    output logic [NPORTS-1:0]         req_done_o,
    output logic [NPORTS-1:0]         grant_o,
    output logic                      error_o,
    output logic [31:0]               ctl_adr_o,
    output logic [2*WIDTH-1:0]        ctl_dat_o,
    output logic                      ctl_reg_space_o,
    output logic                      ctl_rrq_o,
    output logic                      ctl_wrq_o,
    input  logic [2*WIDTH-1:0]        ctl_dat_i,
    input  logic                      ctl_valid_i,
    input  logic                      ctl_ready_i,
    input  logic                      ctl_busy_i,
    input  logic                      ctl_error_i
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, ACTIVE, DONE, ERROR} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     gidx, gidx_nxt;
    logic [PW-1:0]     last, last_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [NPORTS-1:0] pending;
    logic [NPORTS-1:0] gmask;
    logic [PW-1:0]     sel;
    logic [PW-1:0]     win;
    logic              found;
    logic              hold;
    logic              g_rrq;
    logic              g_wrq;
    int                idx;

    assign pending = req_rrq_i | req_wrq_i;
    assign gmask   = {{(NPORTS-1){1'b0}}, 1'b1} << gidx;
    assign hold    = (state == ISSUE) || (state == ACTIVE);
    assign g_rrq   = req_rrq_i[gidx];
    assign g_wrq   = req_wrq_i[gidx];
    assign sel     = hold ? gidx : '0;

    // First pending port after the previous winner, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 1; i <= NPORTS; i++) begin
            idx = (int'(last) + i) % NPORTS;
            if (!found && pending[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gidx_nxt  = gidx;
        last_nxt  = last;
        cnt_nxt   = cnt;
        if (ctl_error_i) begin
            state_nxt = ERROR;
        end else begin
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (found && !ctl_busy_i) begin
                        gidx_nxt  = win;
                        last_nxt  = win;
                        state_nxt = ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_nxt = cnt + 1'b1;
                    if (ctl_busy_i)
                        state_nxt = ACTIVE;
                    else if (!g_rrq && !g_wrq)
                        state_nxt = IDLE;
                    else if (cnt_nxt == CW'(TIMEOUT))
                        state_nxt = ERROR;
                end
                ACTIVE:  if (!ctl_busy_i) state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                ERROR:   state_nxt = ERROR;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            gidx  <= '0;
            last  <= PW'(NPORTS - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            gidx  <= gidx_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A read wins when the owner raises both requests.
    assign ctl_rrq_o   = hold && g_rrq;
    assign ctl_wrq_o   = hold && g_wrq && !g_rrq;
    assign grant_o     = hold ? gmask : '0;
    assign req_done_o  = (state == DONE) ? gmask : '0;
    assign req_valid_o = ((state == ACTIVE) && ctl_valid_i) ? gmask : '0;
    assign req_ready_o = ((state == ACTIVE) && ctl_ready_i) ? gmask : '0;
    assign error_o     = (state == ERROR);
    assign req_dat_o   = ctl_dat_i;

    always_comb begin
        ctl_adr_o       = req_adr_i[31:0];
        ctl_dat_o       = req_dat_i[2*WIDTH-1:0];
        ctl_reg_space_o = req_reg_space_i[0];
        for (int p = 0; p < NPORTS; p++) begin
            if (sel == PW'(p)) begin
                ctl_adr_o       = req_adr_i[p*32 +: 32];
                ctl_dat_o       = req_dat_i[p*2*WIDTH +: 2*WIDTH];
                ctl_reg_space_o = req_reg_space_i[p];
            end
        end
    end

endmodule
